cmem_pp: RTL and testbench

CMEM_PP -- requirements
Module: cmem_pp

---
 rtl/cmem_pkg.sv | 14 +
 rtl/cmem_bank.sv | 44 ++++
 rtl/cmem_pp.sv | 143 ++++++++++++++
 tb/tb_cmem_pp.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmem_pkg.sv
// Shared types and default sizes for the double-buffered coefficient memory.
package cmem_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_DEPTH  = 64;
   localparam int DEF_NPORTS = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_FULL = 2'd2
   } ld_state_t;

endpackage

// File: rtl/cmem_bank.sv
// One coefficient bank: single write port, NPORTS registered read ports.
module cmem_bank
   import cmem_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int NPORTS = DEF_NPORTS,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [AW-1:0]            waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [NPORTS*AW-1:0]     raddr,
   output logic [NPORTS*WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Addresses past the last word (non-power-of-two DEPTH) read as zero.
   function automatic logic [WIDTH-1:0] rd_word(input logic [AW-1:0] a);
      if ({1'b0, a} < (AW+1)'(DEPTH))
         return mem[a];
      else
         return '0;
   endfunction

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         for (int p = 0; p < NPORTS; p++)
            rdata[p*WIDTH +: WIDTH] <= rd_word(raddr[p*AW +: AW]);
      end
   end

endmodule

// File: rtl/cmem_pp.sv
// Ping-pong coefficient memory: shadow bank is loaded while the active bank serves reads.
// state | meaning
// IDLE  | no load in progress, swap requests rejected
// LOAD  | accepting words into the shadow bank
// FULL  | shadow bank complete, waiting for swap
module cmem_pp
   import cmem_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int NPORTS = DEF_NPORTS,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rd_en,
   input  logic [NPORTS*AW-1:0]     rd_addr,
   output logic [NPORTS*WIDTH-1:0]  rd_data,
   output logic                     rd_valid,
   input  logic                     ld_start,
   input  logic                     ld_valid,
   input  logic [WIDTH-1:0]         ld_data,
   output logic                     ld_ready,
   input  logic                     swap_req,
   output logic                     swap_ack,
   output logic                     swap_err,
   output logic                     active_bank,
   output logic [AW:0]              load_cnt
);

   localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

   ld_state_t                 state, state_nxt;
   logic [AW:0]               load_cnt_nxt;
   logic                      active_bank_nxt;
   logic                      swap_ack_nxt, swap_err_nxt;
   logic                      wr_en;
   logic                      rd_en_q, bank_q;
   logic [NPORTS*WIDTH-1:0]   q0, q1;

   assign ld_ready = (state == ST_LOAD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         load_cnt    <= '0;
         active_bank <= 1'b0;
         swap_ack    <= 1'b0;
         swap_err    <= 1'b0;
      end else begin
         state       <= state_nxt;
         load_cnt    <= load_cnt_nxt;
         active_bank <= active_bank_nxt;
         swap_ack    <= swap_ack_nxt;
         swap_err    <= swap_err_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      load_cnt_nxt    = load_cnt;
      active_bank_nxt = active_bank;
      swap_ack_nxt    = 1'b0;
      swap_err_nxt    = 1'b0;
      wr_en           = 1'b0;
      case (state)
         ST_IDLE: begin
            swap_err_nxt = swap_req;
            if (ld_start) begin
               state_nxt    = ST_LOAD;
               load_cnt_nxt = '0;
            end
         end
         ST_LOAD: begin
            swap_err_nxt = swap_req;
            // A restart on the same cycle as a transfer drops that word.
            if (ld_start) begin
               load_cnt_nxt = '0;
            end else if (ld_valid) begin
               wr_en        = 1'b1;
               load_cnt_nxt = load_cnt + 1'b1;
               if (load_cnt == LAST_IDX)
                  state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (swap_req) begin
               active_bank_nxt = ~active_bank;
               swap_ack_nxt    = 1'b1;
               load_cnt_nxt    = '0;
               state_nxt       = ST_IDLE;
            end else if (ld_start) begin
               load_cnt_nxt = '0;
               state_nxt    = ST_LOAD;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Reads follow the bank selected after this edge, so a read sampled on the
   // swap edge already sees the new bank; only that bank is read.
   cmem_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NPORTS(NPORTS)) u_bank0 (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en & active_bank),
      .waddr (load_cnt[AW-1:0]),
      .wdata (ld_data),
      .re    (rd_en & ~active_bank_nxt),
      .raddr (rd_addr),
      .rdata (q0)
   );

   cmem_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NPORTS(NPORTS)) u_bank1 (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en & ~active_bank),
      .waddr (load_cnt[AW-1:0]),
      .wdata (ld_data),
      .re    (rd_en & active_bank_nxt),
      .raddr (rd_addr),
      .rdata (q1)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_en_q  <= 1'b0;
         bank_q   <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_en_q  <= rd_en;
         rd_valid <= rd_en_q;
         if (rd_en)
            bank_q <= active_bank_nxt;
         if (rd_en_q)
            rd_data <= bank_q ? q1 : q0;
      end
   end

endmodule

// File: tb/tb_cmem_pp.sv
// Directed bench for cmem_pp with hand-computed expected values.
module tb_cmem_pp;

   localparam int WIDTH  = 16;
   localparam int DEPTH  = 64;
   localparam int NPORTS = 8;
   localparam int AW     = 6;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     rd_en;
   logic [NPORTS*AW-1:0]     rd_addr;
   logic [NPORTS*WIDTH-1:0]  rd_data;
   logic                     rd_valid;
   logic                     ld_start;
   logic                     ld_valid;
   logic [WIDTH-1:0]         ld_data;
   logic                     ld_ready;
   logic                     swap_req;
   logic                     swap_ack;
   logic                     swap_err;
   logic                     active_bank;
   logic [AW:0]              load_cnt;

   int vec_cnt = 0;
   int err_cnt = 0;

   cmem_pp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NPORTS(NPORTS)) dut (
      .clk         (clk),
      .rst         (rst),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .ld_start    (ld_start),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_ready    (ld_ready),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack),
      .swap_err    (swap_err),
      .active_bank (active_bank),
      .load_cnt    (load_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rep(input logic [15:0] w);
      logic [127:0] r;
      r = '0;
      for (int p = 0; p < NPORTS; p++) r[p*16 +: 16] = w;
      return r;
   endfunction

   task automatic load_n(input int n, input logic [15:0] base, input logic [15:0] stp);
      for (int i = 0; i < n; i++) begin
         ld_valid = 1'b1;
         ld_data  = base + 16'(i) * stp;
         tick();
      end
      ld_valid = 1'b0;
   endtask

   task automatic do_swap();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [NPORTS*AW-1:0] addr,
                         input logic [127:0] exp);
      rd_addr = addr;
      rd_en   = 1'b1;
      tick();
      rd_en = 1'b0;
      chk({tag, "_valid_early"}, 128'(rd_valid), 128'd0);
      tick();
      chk({tag, "_valid"}, 128'(rd_valid), 128'd1);
      chk({tag, "_data"}, 128'(rd_data), exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NPORTS*AW-1:0] a;
      logic [127:0]         e;
      int                   acc;
      int                   cyc;
      logic                 v;

      rst = 1'b1; rd_en = 1'b0; rd_addr = '0; ld_start = 1'b0; ld_valid = 1'b0;
      ld_data = '0; swap_req = 1'b0;
      tick(); tick();
      chk("rst_active_bank", 128'(active_bank), 128'd0);
      chk("rst_load_cnt",    128'(load_cnt),    128'd0);
      chk("rst_ld_ready",    128'(ld_ready),    128'd0);
      chk("rst_rd_valid",    128'(rd_valid),    128'd0);
      chk("rst_rd_data",     128'(rd_data),     128'd0);
      chk("rst_swap_ack",    128'(swap_ack),    128'd0);
      chk("rst_swap_err",    128'(swap_err),    128'd0);
      rst = 1'b0;
      tick();

      // First load 0..63, swap, stride-8 reads
      ld_start = 1'b1; tick(); ld_start = 1'b0;
      chk("l1_ready", 128'(ld_ready), 128'd1);
      chk("l1_cnt0",  128'(load_cnt), 128'd0);
      load_n(64, 16'h0000, 16'h0001);
      chk("l1_cnt64", 128'(load_cnt), 128'd64);
      chk("l1_full_ready", 128'(ld_ready), 128'd0);
      do_swap();
      chk("l1_swap_ack", 128'(swap_ack), 128'd1);
      chk("l1_bank",     128'(active_bank), 128'd1);
      chk("l1_cnt_clr",  128'(load_cnt), 128'd0);
      tick();
      chk("l1_ack_pulse", 128'(swap_ack), 128'd0);
      for (int p = 0; p < NPORTS; p++) begin
         a[p*AW +: AW]  = AW'(8*p);
         e[p*16 +: 16]  = 16'(8*p);
      end
      rd_chk("l1_rd", a, e);
      tick();
      chk("l1_rd_valid_drop", 128'(rd_valid), 128'd0);
      chk("l1_rd_hold",       128'(rd_data),  e);

      // Second load under continuous reads at address 5
      for (int p = 0; p < NPORTS; p++) a[p*AW +: AW] = AW'(5);
      rd_addr = a; rd_en = 1'b1;
      ld_start = 1'b1; tick(); ld_start = 1'b0;
      load_n(32, 16'h1000, 16'h0001);
      chk("l2_mid_rd", 128'(rd_data), rep(16'h0005));
      load_n(32, 16'h1020, 16'h0001);
      chk("l2_pre_rd",    128'(rd_data),  rep(16'h0005));
      chk("l2_pre_valid", 128'(rd_valid), 128'd1);
      do_swap();
      chk("l2_swap_ack",   128'(swap_ack),    128'd1);
      chk("l2_bank",       128'(active_bank), 128'd0);
      chk("l2_swap_edge_rd", 128'(rd_data),   rep(16'h0005));
      tick();
      chk("l2_post_rd", 128'(rd_data), rep(16'h1005));
      rd_en = 1'b0;
      tick(); tick();

      // Premature swap after 30 words
      ld_start = 1'b1; tick(); ld_start = 1'b0;
      load_n(30, 16'h2000, 16'h0001);
      do_swap();
      chk("l3_swap_err",  128'(swap_err),    128'd1);
      chk("l3_no_ack",    128'(swap_ack),    128'd0);
      chk("l3_bank",      128'(active_bank), 128'd0);
      chk("l3_ready",     128'(ld_ready),    128'd1);
      chk("l3_cnt",       128'(load_cnt),    128'd30);
      tick();
      chk("l3_err_pulse", 128'(swap_err),    128'd0);

      // Restart after 10 words, including a dropped word on the restart cycle
      ld_start = 1'b1; tick(); ld_start = 1'b0;
      load_n(10, 16'h3100, 16'h0001);
      chk("l4_cnt10", 128'(load_cnt), 128'd10);
      ld_start = 1'b1; ld_valid = 1'b1; ld_data = 16'hDEAD;
      tick();
      ld_start = 1'b0; ld_valid = 1'b0;
      chk("l4_restart_cnt",   128'(load_cnt), 128'd0);
      chk("l4_restart_ready", 128'(ld_ready), 128'd1);
      load_n(64, 16'hA5A5, 16'h0000);
      chk("l4_cnt64", 128'(load_cnt), 128'd64);
      do_swap();
      chk("l4_bank",   128'(active_bank), 128'd1);
      chk("l4_cnt_clr", 128'(load_cnt),   128'd0);
      for (int r = 0; r < DEPTH / NPORTS; r++) begin
         for (int p = 0; p < NPORTS; p++) a[p*AW +: AW] = AW'(r*NPORTS + p);
         rd_chk($sformatf("l4_rd%0d", r), a, rep(16'hA5A5));
      end

      // Reset mid-load
      ld_start = 1'b1; tick(); ld_start = 1'b0;
      rd_addr = '0; rd_en = 1'b1;
      load_n(20, 16'h4000, 16'h0001);
      chk("l5_cnt20",  128'(load_cnt), 128'd20);
      chk("l5_valid",  128'(rd_valid), 128'd1);
      chk("l5_rd",     128'(rd_data),  rep(16'hA5A5));
      rst = 1'b1;
      #1;
      chk("l5_rst_bank",  128'(active_bank), 128'd0);
      chk("l5_rst_ready", 128'(ld_ready),    128'd0);
      chk("l5_rst_cnt",   128'(load_cnt),    128'd0);
      chk("l5_rst_valid", 128'(rd_valid),    128'd0);
      chk("l5_rst_data",  128'(rd_data),     128'd0);
      rd_en = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("l5_post_ready", 128'(ld_ready), 128'd0);

      // Random ld_valid gaps, then swap_req with ld_start in FULL
      ld_start = 1'b1; tick(); ld_start = 1'b0;
      acc = 0; cyc = 0;
      while (acc < 64 && cyc < 2000) begin
         v = 1'($urandom_range(0, 1));
         ld_valid = v;
         ld_data  = 16'h3000 + 16'(acc);
         tick();
         if (v) acc++;
         cyc++;
      end
      ld_valid = 1'b0;
      chk("l6_accept_bound", 128'(acc), 128'd64);
      chk("l6_cnt64", 128'(load_cnt), 128'd64);
      chk("l6_full",  128'(ld_ready), 128'd0);
      swap_req = 1'b1; ld_start = 1'b1;
      tick();
      swap_req = 1'b0; ld_start = 1'b0;
      chk("l6_swap_ack", 128'(swap_ack),    128'd1);
      chk("l6_bank",     128'(active_bank), 128'd1);
      chk("l6_cnt_clr",  128'(load_cnt),    128'd0);
      chk("l6_no_restart", 128'(ld_ready),  128'd0);
      tick();
      chk("l6_idle", 128'(ld_ready), 128'd0);
      for (int p = 0; p < NPORTS; p++) begin
         a[p*AW +: AW] = AW'(8*p + 3);
         e[p*16 +: 16] = 16'h3000 + 16'(8*p + 3);
      end
      rd_chk("l6_rd", a, e);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
